// File: rtl/pipelined_cpa.sv
// Pipelined carry-propagate adder/subtractor with valid/ready flow control.
// Each stage ripples one C-bit chunk; operands travel with the beat and the partial sum accumulates.
module pipelined_cpa #(
  parameter int WIDTH  = 13,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);
  localparam int C    = (WIDTH + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] v_q, v_d, c_q, c_d, o_q, o_d, ld_s;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] src_v, src_c, src_o;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic              cy_s, ci_s;

  // Load enables ripple back from the output; an empty stage always loads
  always_comb begin
    ld_s       = '0;
    ld_s[LAST] = ~v_q[LAST] | out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      ld_s[k] = ~v_q[k] | ld_s[k+1];
    end
  end

  // Stage sources: port operands for stage 0, previous stage registers otherwise
  always_comb begin
    src_v = '0;
    src_c = '0;
    src_o = '0;
    for (int k = 0; k < STAGES; k++) begin
      src_a[k] = '0;
      src_b[k] = '0;
      src_s[k] = '0;
    end
    src_v[0] = in_valid;
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub ? ~cin : cin;
    src_o[0] = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_o[k] = o_q[k-1];
    end
  end

  // Next-state: each loading stage ripples its own chunk; stages past the MSB just pass through
  always_comb begin
    v_d  = v_q;
    c_d  = c_q;
    o_d  = o_q;
    cy_s = 1'b0;
    ci_s = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      if (ld_s[k]) begin
        v_d[k] = src_v[k];
      end else begin
        v_d[k] = v_q[k];
      end
      if (ld_s[k] && src_v[k]) begin
        a_d[k] = src_a[k];
        b_d[k] = src_b[k];
        s_d[k] = src_s[k];
        o_d[k] = src_o[k];
        cy_s   = src_c[k];
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= k * C && i < (k + 1) * C) begin
            ci_s      = cy_s;
            s_d[k][i] = src_a[k][i] ^ src_b[k][i] ^ ci_s;
            cy_s      = (src_a[k][i] & src_b[k][i]) | (ci_s & (src_a[k][i] ^ src_b[k][i]));
            o_d[k]    = (i == WIDTH - 1) ? (ci_s ^ cy_s) : o_d[k];
          end else begin
            s_d[k][i] = src_s[k][i];
          end
        end
        c_d[k] = cy_s;
      end else begin
        c_d[k] = c_q[k];
      end
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      o_q <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      s_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      o_q <= o_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
  end

  assign in_ready  = ld_s[0];
  assign out_valid = v_q[LAST];
  assign s         = s_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = o_q[LAST];

endmodule

// File: tb/tb_pipelined_cpa.sv
// Bench for pipelined_cpa: directed vectors and corner sequences on STAGES=4, plus a
// scoreboarded random sweep running STAGES=4/1/13/6 side by side.
module tb_pipelined_cpa;
  localparam int W = 13;
  localparam int N = 4;
  localparam int DEP [N] = '{4, 1, 13, 6};

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  logic         clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic         sub = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [N-1:0] ir, ov, co, of;
  logic [W-1:0] so [N];
  int           n_chk = 0, n_fail = 0;
  exp_t         sbq [N][$];
  logic [N-1:0] stall_q = '0;
  logic [W-1:0] stall_s [N];
  vec_t         tbl [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    pipelined_cpa #(.WIDTH(W), .STAGES(DEP[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[g]),
      .a(a), .b(b), .sub(sub), .cin(cin),
      .out_valid(ov[g]), .out_ready(out_ready),
      .s(so[g]), .cout(co[g]), .overflow(of[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: A + B' + c0 as plain wide arithmetic; overflow from operand/result signs
  function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fsub, input logic fcin);
    logic [W-1:0] bp;
    logic [W:0]   t;
    exp_t         e;
    bp   = fsub ? ~fb : fb;
    t    = {1'b0, fa} + {1'b0, bp} + {{W{1'b0}}, fsub ^ fcin};
    e.s  = t[W-1:0];
    e.co = t[W];
    e.ov = (fa[W-1] == bp[W-1]) && (e.s[W-1] != fa[W-1]);
    return e;
  endfunction

  // Scoreboard monitor for every instance, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sbq[i].delete();
      stall_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("in_ready[%0d]", i), 32'(ir[i]),
            32'((sbq[i].size() < DEP[i]) || out_ready));
        if (stall_q[i]) begin
          chk($sformatf("hold_valid[%0d]", i), 32'(ov[i]), 32'd1);
          chk($sformatf("hold_s[%0d]", i), 32'(so[i]), 32'(stall_s[i]));
        end
        if (ov[i] && out_ready) begin
          if (sbq[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_out[%0d] actual=%0h required=no_beat", i, so[i]);
          end else begin
            e = sbq[i].pop_front();
            chk($sformatf("sb_s[%0d]", i), 32'(so[i]), 32'(e.s));
            chk($sformatf("sb_cout[%0d]", i), 32'(co[i]), 32'(e.co));
            chk($sformatf("sb_ovf[%0d]", i), 32'(of[i]), 32'(e.ov));
          end
        end
        if (in_valid && ir[i]) sbq[i].push_back(model(a, b, sub, cin));
        stall_q[i] <= ov[i] && !out_ready;
        stall_s[i] <= so[i];
      end
    end
  end

  // Single beat through an idle pipe: exactly STAGES cycles of latency on the 4-stage instance
  task automatic apply_vec(input vec_t v, input string nm);
    @(posedge clk); #1;
    in_valid = 1'b1; a = v.a; b = v.b; sub = v.sub; cin = v.cin; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({nm, "_early"}, 32'(ov[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(ov[0]), 32'd1);
    chk({nm, "_s"}, 32'(so[0]), 32'(v.s));
    chk({nm, "_cout"}, 32'(co[0]), 32'(v.co));
    chk({nm, "_ovf"}, 32'(of[0]), 32'(v.ov));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int j;
    tbl[0] = '{13'h0FFF, 13'h0001, 1'b0, 1'b0, 13'h1000, 1'b0, 1'b1};
    tbl[1] = '{13'h1FFF, 13'h0001, 1'b0, 1'b0, 13'h0000, 1'b1, 1'b0};
    tbl[2] = '{13'h1FFF, 13'h1FFF, 1'b0, 1'b1, 13'h1FFF, 1'b1, 1'b0};
    tbl[3] = '{13'h0005, 13'h0007, 1'b1, 1'b0, 13'h1FFE, 1'b0, 1'b0};
    tbl[4] = '{13'h1000, 13'h0001, 1'b1, 1'b0, 13'h0FFF, 1'b1, 1'b1};
    tbl[5] = '{13'h000A, 13'h0003, 1'b1, 1'b1, 13'h0006, 1'b1, 1'b0};
    tbl[6] = '{13'h0000, 13'h0000, 1'b1, 1'b0, 13'h0000, 1'b1, 1'b0};
    tbl[7] = '{13'h0AAA, 13'h1555, 1'b0, 1'b1, 13'h0000, 1'b1, 1'b0};

    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_valid[%0d]", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst_s[%0d]", i), 32'(so[i]), 32'd0);
      chk($sformatf("rst_cout[%0d]", i), 32'(co[i]), 32'd0);
      chk($sformatf("rst_ovf[%0d]", i), 32'(of[i]), 32'd0);
      chk($sformatf("rst_in_ready[%0d]", i), 32'(ir[i]), 32'd1);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) apply_vec(tbl[k], $sformatf("vec%0d", k));

    // Back-to-back stream: results on consecutive cycles 4..11
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 8); a = 13'(c + 1); b = 13'(3 * (c + 1)); sub = 1'b0; cin = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b_valid_c%0d", c), 32'(ov[0]), 32'(c >= 4 && c <= 11));
      if (c >= 4 && c <= 11) chk($sformatf("b2b_s_c%0d", c), 32'(so[0]), 32'(4 * (c - 3)));
    end

    // Backpressure: out_ready low for cycles 5..9 while 8 beats are offered
    j = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      in_valid = (j < 8); a = 13'(100 + 7 * j); b = 13'(j); sub = j[0]; cin = j[1];
      out_ready = !(c >= 5 && c <= 9);
      @(negedge clk);
      if (c == 9) begin
        chk("bp_in_ready_full", 32'(ir[0]), 32'd0);
        chk("bp_out_valid_held", 32'(ov[0]), 32'd1);
      end
      if (in_valid && ir[0]) j++;
    end
    chk("bp_all_accepted", 32'(j), 32'd8);
    @(posedge clk); #1;
    chk("bp_drained", 32'(sbq[0].size()), 32'd0);

    // Reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = 13'(k + 1); b = 13'(k); sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_valid", 32'(ov[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(ov[0]), 32'd0);
    chk("rst_async_s", 32'(so[0]), 32'd0);
    chk("rst_async_in_ready", 32'(ir[0]), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rst_no_stale_c%0d", c), 32'(ov[0]), 32'd0);
    end
    apply_vec(tbl[4], "post_rst");

    // Random sweep across all pipeline depths
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 13'($urandom);
      b         = 13'($urandom);
      sub       = 1'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) begin
        a = '1;
        b = '1;
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("drain[%0d]", i), 32'(sbq[i].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
